mmio_queue_afu: RTL

MMIO_QUEUE_AFU -- requirements
Module: mmio_queue_afu

---
 rtl/ccip_if_pkg.sv | 73 +++++++
 rtl/mmio_queue_pkg.sv | 39 +++
 rtl/mmio_queue_ch.sv | 70 +++++++
 rtl/mmio_queue_afu.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ccip_if_pkg.sv
// CCI-P interface types: the subset of the platform channel structs this AFU exchanges
// with the FIU. Field names and ordering follow the platform package.
package ccip_if_pkg;

  localparam int CCIP_CLDATA_WIDTH   = 512;
  localparam int CCIP_MMIOADDR_WIDTH = 16;
  localparam int CCIP_TID_WIDTH      = 9;
  localparam int CCIP_MMIODATA_WIDTH = 64;
  localparam int CCIP_C0RX_HDR_WIDTH = 28;

  typedef logic [CCIP_CLDATA_WIDTH-1:0]   t_ccip_clData;
  typedef logic [CCIP_MMIOADDR_WIDTH-1:0] t_ccip_mmioAddr;
  typedef logic [CCIP_TID_WIDTH-1:0]      t_ccip_tid;
  typedef logic [CCIP_MMIODATA_WIDTH-1:0] t_ccip_mmioData;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  // Raw c0 header; its meaning depends on which valid is set.
  typedef logic [CCIP_C0RX_HDR_WIDTH-1:0] t_ccip_c0_RspHdr;

  typedef struct packed {
    t_ccip_c0_RspHdr hdr;
    t_ccip_clData    data;
    logic            rspValid;
    logic            mmioRdValid;
    logic            mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [27:0] hdr;
    logic        rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef struct packed {
    logic [73:0] hdr;
    logic        valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic [79:0]  hdr;
    t_ccip_clData data;
    logic         valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

endpackage

// File: rtl/mmio_queue_pkg.sv
// Register map constants for the MMIO queue AFU: DFH, AFU_ID, channel layout and
// STATUS word bit positions.
package mmio_queue_pkg;

  localparam logic [15:0] DFH_ADDR   = 16'h0000;
  localparam logic [15:0] ID_L_ADDR  = 16'h0002;
  localparam logic [15:0] ID_H_ADDR  = 16'h0004;
  localparam logic [15:0] NEXT_ADDR  = 16'h0006;
  localparam logic [15:0] RSVD_ADDR  = 16'h0008;

  // AFU feature header: type AFU in [63:60], end-of-list at bit 40.
  localparam logic [63:0] AFU_DFH    = 64'h1000_0100_0000_0000;
  localparam logic [63:0] AFU_ID_L   = 64'h9A3F_5C21_7B04_E6D8;
  localparam logic [63:0] AFU_ID_H   = 64'h4D2C_81F0_36AB_5E97;

  localparam int          CH_STRIDE  = 4;
  localparam logic [15:0] DATA_OFS   = 16'h0000;
  localparam logic [15:0] STATUS_OFS = 16'h0002;

  localparam int ST_EMPTY_BIT  = 0;
  localparam int ST_FULL_BIT   = 1;
  localparam int ST_OVF_BIT    = 2;
  localparam int ST_UNF_BIT    = 3;
  localparam int ST_COUNT_LSB  = 8;

  function automatic logic [63:0] pack_status(input logic [7:0] count, input logic unf,
                                              input logic ovf, input logic full,
                                              input logic empty);
    logic [63:0] word;
    word = '0;
    word[ST_EMPTY_BIT] = empty;
    word[ST_FULL_BIT]  = full;
    word[ST_OVF_BIT]   = ovf;
    word[ST_UNF_BIT]   = unf;
    word[ST_COUNT_LSB +: 8] = count;
    return word;
  endfunction

endpackage

// File: rtl/mmio_queue_ch.sv
// One queue channel: circular buffer with occupancy count and sticky overflow/underflow.
// Popped data appears on 'data' the cycle after 'pop' (0 when the pop hit an empty queue).
module mmio_queue_ch #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [63:0]                  wr_data,
  input  logic                         pop,
  input  logic                         clr_flags,
  output logic [63:0]                  data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [63:0]      mem [DEPTH];
  logic [63:0]      data_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;
  logic             unf_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push onto a full queue still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      if (clr_flags) begin
        ovf_reg <= 1'b0;
        unf_reg <= 1'b0;
      end
      if (push && !do_push) ovf_reg <= 1'b1;
      if (pop && empty)     unf_reg <= 1'b1;
    end
  end

  // Storage is left unreset so it maps onto block RAM; read-before-write on a shared slot.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
    if (pop)     data_reg <= do_pop ? mem[rd_ptr_reg] : '0;
  end

  assign data  = data_reg;
  assign count = count_reg;
  assign ovf   = ovf_reg;
  assign unf   = unf_reg;

endmodule

// File: rtl/mmio_queue_afu.sv
// CCI-P AFU exposing NUM_CH independent 64-bit FIFOs over MMIO: a write to DATA pushes,
// a read of DATA pops, STATUS reports occupancy and sticky error flags.
module mmio_queue_afu
  import ccip_if_pkg::*, mmio_queue_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  t_if_ccip_Rx rx,
  output t_if_ccip_Tx tx
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  t_ccip_c0_ReqMmioHdr mmio_hdr;
  logic                rd_req;
  logic                wr_req;
  logic [15:0]         addr;
  logic [63:0]         wr_data;

  assign mmio_hdr = t_ccip_c0_ReqMmioHdr'(rx.c0.hdr);
  assign rd_req   = rx.c0.mmioRdValid;
  assign wr_req   = rx.c0.mmioWrValid;
  assign addr     = mmio_hdr.address;
  assign wr_data  = rx.c0.data[63:0];

  logic [NUM_CH-1:0] hit_data;
  logic [NUM_CH-1:0] hit_status;
  logic [NUM_CH-1:0] ch_push;
  logic [NUM_CH-1:0] ch_pop;
  logic [NUM_CH-1:0] ch_clr;
  logic [NUM_CH-1:0] ch_full;
  logic [NUM_CH-1:0] ch_empty;
  logic [NUM_CH-1:0] ch_ovf;
  logic [NUM_CH-1:0] ch_unf;
  logic [63:0]       ch_data     [NUM_CH];
  logic [CNT_W-1:0]  ch_count    [NUM_CH];
  logic [63:0]       status_word [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign hit_data[gi]   = (addr == BASE_ADDR + 16'(CH_STRIDE * gi) + DATA_OFS);
      assign hit_status[gi] = (addr == BASE_ADDR + 16'(CH_STRIDE * gi) + STATUS_OFS);
      assign ch_push[gi]    = wr_req && hit_data[gi];
      assign ch_pop[gi]     = rd_req && hit_data[gi];
      assign ch_clr[gi]     = wr_req && hit_status[gi];
      // Count is reported in an 8-bit field; with DEPTH=256 a full queue shows 0 plus full=1.
      assign status_word[gi] = pack_status(8'(ch_count[gi]), ch_unf[gi], ch_ovf[gi],
                                           ch_full[gi], ch_empty[gi]);

      mmio_queue_ch #(
        .DEPTH(DEPTH)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .push     (ch_push[gi]),
        .wr_data  (wr_data),
        .pop      (ch_pop[gi]),
        .clr_flags(ch_clr[gi]),
        .data     (ch_data[gi]),
        .count    (ch_count[gi]),
        .full     (ch_full[gi]),
        .empty    (ch_empty[gi]),
        .ovf      (ch_ovf[gi]),
        .unf      (ch_unf[gi])
      );
    end
  endgenerate

  // Non-queue read data is captured here; queue data comes from the channel's read register.
  logic [63:0]     csr_next;
  logic            from_ch_next;
  logic [CH_W-1:0] ch_next;

  always_comb begin
    csr_next     = '0;
    from_ch_next = 1'b0;
    ch_next      = '0;
    case (addr)
      DFH_ADDR:  csr_next = AFU_DFH;
      ID_L_ADDR: csr_next = AFU_ID_L;
      ID_H_ADDR: csr_next = AFU_ID_H;
      default:   csr_next = '0;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit_data[c]) begin
        from_ch_next = 1'b1;
        ch_next      = CH_W'(c);
      end
      if (hit_status[c]) csr_next = status_word[c];
    end
  end

  logic            resp_valid_reg;
  t_ccip_tid       resp_tid_reg;
  logic [63:0]     resp_csr_reg;
  logic            resp_from_ch_reg;
  logic [CH_W-1:0] resp_ch_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_reg   <= 1'b0;
      resp_tid_reg     <= '0;
      resp_csr_reg     <= '0;
      resp_from_ch_reg <= 1'b0;
      resp_ch_reg      <= '0;
    end else begin
      resp_valid_reg <= rd_req;
      if (rd_req) begin
        resp_tid_reg     <= mmio_hdr.tid;
        resp_csr_reg     <= csr_next;
        resp_from_ch_reg <= from_ch_next;
        resp_ch_reg      <= ch_next;
      end
    end
  end

  always_comb begin
    tx                 = '0;
    tx.c2.mmioRdValid  = resp_valid_reg;
    tx.c2.hdr.tid      = resp_tid_reg;
    if (resp_valid_reg) begin
      tx.c2.data = resp_from_ch_reg ? ch_data[resp_ch_reg] : resp_csr_reg;
    end
  end

  logic unused_rx_bits;
  assign unused_rx_bits = ^{rx.c0TxAlmFull, rx.c1TxAlmFull, rx.c1, rx.c0.rspValid,
                            rx.c0.data[511:64], mmio_hdr.length, mmio_hdr.rsvd, NEXT_ADDR,
                            RSVD_ADDR};

endmodule
